hsv_core_commit_sel: RTL

HSV_CORE_COMMIT_SEL -- requirements
Module: hsv_core_commit_sel

---
 rtl/hsv_core_pkg.sv | 36 +++
 rtl/hsv_core_commit_order_fifo.sv | 70 +++++++
 rtl/hsv_core_commit_sel.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hsv_core_pkg.sv
// Shared core types used by the commit stage: retirement actions, trap causes
// and the per-unit commit record that each execution unit presents.
package hsv_core_pkg;

    typedef enum logic [2:0] {
        COMMIT_NEXT      = 3'd0,
        COMMIT_JUMP      = 3'd1,
        COMMIT_EXCEPTION = 3'd2,
        COMMIT_WFI       = 3'd3,
        COMMIT_MODE_RET  = 3'd4
    } commit_action_t;

    typedef enum logic [3:0] {
        EXC_INSN_ADDR_MISALIGNED = 4'd0,
        EXC_ILLEGAL_INSN         = 4'd2,
        EXC_BREAKPOINT           = 4'd3,
        EXC_ECALL                = 4'd11,
        EXC_HARDWARE_ERROR       = 4'd15
    } exc_cause_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
    } commit_common_t;

    typedef struct packed {
        commit_common_t common;
        commit_action_t action;
        logic           writeback;
        logic [31:0]    result;
        logic [31:0]    next_pc;
        exc_cause_t     exc_cause;
        logic [31:0]    exc_value;
    } commit_data_t;

endpackage

// File: rtl/hsv_core_commit_order_fifo.sv
// Program-order FIFO of execution-unit indices feeding the commit selector.
// Push and pop in the same cycle are allowed even when full; flush empties it.
module hsv_core_commit_order_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 2
) (
    input  logic                     clk_core,
    input  logic                     rst_core,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk_core) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/hsv_core_commit_sel.sv
// In-order commit selector: retires the head unit's result, drives writeback,
// redirect/trap pulses and the flush handshake. HSV_COMMIT_PERF_EN adds retired_o.
//
// state          | meaning
// ST_RUN         | dispatch and retirement enabled
// ST_FLUSH_ENTER | flush requested, waiting for every unit to ack
// ST_FLUSH_EXIT  | all acked, waiting for every ack to drop
module hsv_core_commit_sel
    import hsv_core_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int ORDER_DEPTH = 8
) (
    input  logic                           clk_core,
    input  logic                           rst_core,
    input  logic [$clog2(NUM_UNITS)-1:0]   disp_unit_i,
    input  logic                           disp_valid_i,
    output logic                           disp_ready_o,
    input  commit_data_t [NUM_UNITS-1:0]   unit_data_i,
    input  logic [NUM_UNITS-1:0]           unit_valid_i,
    output logic [NUM_UNITS-1:0]           unit_ready_o,
`ifdef HSV_COMMIT_PERF_EN
    output logic [63:0]                    retired_o,
`endif
    output logic                           wb_en_o,
    output logic [4:0]                     wb_rd_o,
    output logic [31:0]                    wb_data_o,
    output logic                           redirect_o,
    output logic [31:0]                    redirect_pc_o,
    output commit_action_t                 redirect_action_o,
    output exc_cause_t                     exc_cause_o,
    output logic [31:0]                    exc_value_o,
    output logic                           flush_req_o,
    input  logic [NUM_UNITS-1:0]           flush_ack_i
);
    localparam int UW = $clog2(NUM_UNITS);
    localparam int CW = $clog2(ORDER_DEPTH) + 1;

    localparam logic [1:0] ST_RUN         = 2'd0;
    localparam logic [1:0] ST_FLUSH_ENTER = 2'd1;
    localparam logic [1:0] ST_FLUSH_EXIT  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [UW-1:0]  head_unit;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    logic           fifo_full_unused;
    logic           run, head_ok, push, retire, is_redirect, flush;
    commit_data_t   head_data;

    logic           wb_en_q, redirect_q;
    logic [4:0]     wb_rd_q;
    logic [31:0]    wb_data_q, redirect_pc_q, exc_value_q;
    commit_action_t redirect_action_q;
    exc_cause_t     exc_cause_q;

    assign run          = (state_q == ST_RUN);
    assign disp_ready_o = run && (fifo_count < CW'(ORDER_DEPTH));
    assign push         = disp_valid_i && disp_ready_o;
    assign head_ok      = run && !fifo_empty;
    assign unit_ready_o = head_ok ? (NUM_UNITS'(1) << head_unit) : '0;
    assign head_data    = unit_data_i[head_unit];
    assign retire       = head_ok && unit_valid_i[head_unit];
    assign is_redirect  = (head_data.action != COMMIT_NEXT);
    assign flush        = retire && is_redirect;
    assign flush_req_o  = (state_q == ST_FLUSH_ENTER);

    hsv_core_commit_order_fifo #(
        .DEPTH (ORDER_DEPTH),
        .W     (UW)
    ) u_order_fifo (
        .clk_core    (clk_core),
        .rst_core    (rst_core),
        .push_i      (push),
        .push_data_i (disp_unit_i),
        .pop_i       (retire),
        .flush_i     (flush),
        .head_o      (head_unit),
        .count_o     (fifo_count),
        .full_o      (fifo_full_unused),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:         if (flush) state_d = ST_FLUSH_ENTER;
            ST_FLUSH_ENTER: if (&flush_ack_i) state_d = ST_FLUSH_EXIT;
            ST_FLUSH_EXIT:  if (~|flush_ack_i) state_d = ST_RUN;
            default:        state_d = ST_FLUSH_ENTER;
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) state_q <= ST_FLUSH_ENTER;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            wb_en_q           <= 1'b0;
            wb_rd_q           <= '0;
            wb_data_q         <= '0;
            redirect_q        <= 1'b0;
            redirect_pc_q     <= '0;
            redirect_action_q <= COMMIT_NEXT;
            exc_cause_q       <= EXC_INSN_ADDR_MISALIGNED;
            exc_value_q       <= '0;
        end else begin
            wb_en_q    <= 1'b0;
            redirect_q <= 1'b0;
            if (retire) begin
                wb_rd_q   <= head_data.common.rd;
                wb_data_q <= head_data.result;
                if (head_data.action == COMMIT_NEXT || head_data.action == COMMIT_JUMP)
                    wb_en_q <= head_data.writeback && (head_data.common.rd != 5'd0);
                if (is_redirect) begin
                    redirect_q        <= 1'b1;
                    redirect_action_q <= head_data.action;
                    // Traps restart at the faulting pc; everything else continues at next_pc.
                    redirect_pc_q     <= (head_data.action == COMMIT_EXCEPTION) ?
                                         head_data.common.pc : head_data.next_pc;
                end
                if (head_data.action == COMMIT_EXCEPTION) begin
                    exc_cause_q <= head_data.exc_cause;
                    exc_value_q <= head_data.exc_value;
                end
            end
        end
    end

    assign wb_en_o           = wb_en_q;
    assign wb_rd_o           = wb_rd_q;
    assign wb_data_o         = wb_data_q;
    assign redirect_o        = redirect_q;
    assign redirect_pc_o     = redirect_pc_q;
    assign redirect_action_o = redirect_action_q;
    assign exc_cause_o       = exc_cause_q;
    assign exc_value_o       = exc_value_q;

`ifdef HSV_COMMIT_PERF_EN
    logic [63:0] retired_q;

    always_ff @(posedge clk_core) begin
        if (rst_core)    retired_q <= '0;
        else if (retire) retired_q <= retired_q + 64'd1;
    end

    assign retired_o = retired_q;
`endif

endmodule
